platform_scroller: RTL and testbench



---
 rtl/platform_scroller.sv | 220 ++++++++++++++++++++++
 tb/tb_platform_scroller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_scroller.sv
// Platform chain with pseudo-random generation and a smooth scroll toward the base position.
// Optional auto-advance after an idle hold is enabled by defining PLAT_AUTO_ADVANCE_EN.
module platform_scroller #(
  parameter int unsigned NUM_SQ      = 3,
  parameter int unsigned COORD_W     = 8,
  parameter int unsigned DIST_MIN    = 13,
  parameter int unsigned DIST_RND_W  = 3,
  parameter int unsigned STEP_SFT    = 4,
  parameter int unsigned BASE_Y      = 100,
  parameter int unsigned BASE_XR     = 20,
  parameter int unsigned BASE_XL     = 40,
  parameter int unsigned INIT_LAYOUT = 1,
  parameter logic [15:0] SEED        = 16'hACE1
`ifdef PLAT_AUTO_ADVANCE_EN
  ,
  parameter int unsigned IDLE_HOLD   = 200
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adv,
  output logic [NUM_SQ*COORD_W-1:0]  plat_x,
  output logic [NUM_SQ*COORD_W-1:0]  plat_y,
  output logic [NUM_SQ-1:0]          plat_color,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned RW = STEP_SFT + 1;
  localparam int unsigned DW = COORD_W + 1;
  localparam int unsigned LW = NUM_SQ - 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GEN    = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [RW-1:0]      RATIO_END = RW'(2 ** STEP_SFT);
  localparam logic [COORD_W-1:0] DMIN_C    = COORD_W'(DIST_MIN);
  localparam logic [COORD_W-1:0] BASE_Y_C  = COORD_W'(BASE_Y);
  localparam logic [COORD_W-1:0] BASE_XR_C = COORD_W'(BASE_XR);
  localparam logic [COORD_W-1:0] BASE_XL_C = COORD_W'(BASE_XL);
  localparam logic [15:0]        LFSR_TAPS = 16'hB400;

  function automatic logic [NUM_SQ-1:0] alt_color();
    logic [NUM_SQ-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_SQ; i++) c[i] = (i % 2 == 0);
    return c;
  endfunction

  localparam logic [NUM_SQ-1:0] COLOR_INIT = alt_color();

  // Shifts the chain down by one platform and appends the new far-end bit.
  function automatic logic [LW-1:0] push_layout(input logic [LW-1:0] lay, input logic nb);
    logic [LW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i + 2 < NUM_SQ; i++) r[i] = lay[i+1];
    r[LW-1] = nb;
    return r;
  endfunction

  logic [1:0]                   state_q, state_d;
  logic [LW-1:0]                layout_q, layout_d;
  logic [LW*COORD_W-1:0]        dist_q, dist_d;
  logic [NUM_SQ-1:0]            color_q, color_d;
  logic [RW-1:0]                ratio_q, ratio_d;
  logic signed [DW-1:0]         diffx_q, diffx_d;
  logic signed [DW-1:0]         diffy_q, diffy_d;
  logic [15:0]                  lfsr_q, lfsr_d;
  logic                         nlay_q, nlay_d;
  logic                         ncol_q, ncol_d;
  logic [COORD_W-1:0]           ndist_q, ndist_d;

  logic                         adv_eff;
  logic                         nlay_gen;
  logic [LW-1:0]                layout_gen;
  logic [COORD_W-1:0]           base_gen;
  logic [COORD_W-1:0]           px [NUM_SQ];
  logic [COORD_W-1:0]           py [NUM_SQ];
  logic signed [DW+RW:0]        prodx, prody;
  logic [COORD_W-1:0]           offx, offy;

`ifdef PLAT_AUTO_ADVANCE_EN
  localparam int unsigned CNT_W = (IDLE_HOLD > 1) ? $clog2(IDLE_HOLD) : 1;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             auto_adv;

  // The last idle cycle before the hold expires raises the advance, so exactly
  // IDLE_HOLD idle cycles pass before busy rises.
  assign auto_adv = (state_q == S_IDLE) && (idle_cnt_q == CNT_W'(IDLE_HOLD - 1));
  assign adv_eff  = adv | auto_adv;

  always_comb begin
    idle_cnt_d = '0;
    if (state_q == S_IDLE && !adv_eff) idle_cnt_d = idle_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`else
  assign adv_eff = adv;
`endif

  always_comb begin
    px[0] = layout_q[0] ? BASE_XL_C : BASE_XR_C;
    py[0] = BASE_Y_C;
    for (int unsigned i = 1; i < NUM_SQ; i++) begin
      px[i] = layout_q[i-1] ? px[i-1] - dist_q[(i-1)*COORD_W +: COORD_W]
                            : px[i-1] + dist_q[(i-1)*COORD_W +: COORD_W];
      py[i] = py[i-1] - dist_q[(i-1)*COORD_W +: COORD_W];
    end
  end

  always_comb begin
    prodx = diffx_q * $signed({1'b0, ratio_q});
    prody = diffy_q * $signed({1'b0, ratio_q});
    offx  = '0;
    offy  = '0;
    if (state_q == S_SHIFT) begin
      offx = COORD_W'(prodx >>> STEP_SFT);
      offy = COORD_W'(prody >>> STEP_SFT);
    end
  end

  always_comb begin
    plat_x = '0;
    plat_y = '0;
    for (int unsigned i = 0; i < NUM_SQ; i++) begin
      plat_x[i*COORD_W +: COORD_W] = px[i] + offx;
      plat_y[i*COORD_W +: COORD_W] = py[i] + offy;
    end
  end

  assign plat_color = color_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_COMMIT);

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  // The scroll target is where platform 1 will sit once it becomes platform 0.
  assign nlay_gen   = (lfsr_q[3:0] > 4'd13) ? layout_q[LW-1] : ~layout_q[LW-1];
  assign layout_gen = push_layout(layout_q, nlay_gen);
  assign base_gen   = layout_gen[0] ? BASE_XL_C : BASE_XR_C;

  always_comb begin
    state_d  = state_q;
    layout_d = layout_q;
    dist_d   = dist_q;
    color_d  = color_q;
    ratio_d  = ratio_q;
    diffx_d  = diffx_q;
    diffy_d  = diffy_q;
    nlay_d   = nlay_q;
    ncol_d   = ncol_q;
    ndist_d  = ndist_q;
    unique case (state_q)
      S_IDLE: begin
        if (adv_eff) state_d = S_GEN;
      end
      S_GEN: begin
        nlay_d  = nlay_gen;
        ncol_d  = lfsr_q[4];
        ndist_d = DMIN_C + COORD_W'(lfsr_q[5 +: DIST_RND_W]);
        diffx_d = $signed({1'b0, base_gen}) - $signed({1'b0, px[1]});
        diffy_d = $signed({1'b0, BASE_Y_C}) - $signed({1'b0, py[1]});
        ratio_d = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (ratio_q == RATIO_END) begin
          layout_d = push_layout(layout_q, nlay_q);
          color_d  = {ncol_q, color_q[NUM_SQ-1:1]};
          for (int unsigned i = 0; i + 2 < NUM_SQ; i++)
            dist_d[i*COORD_W +: COORD_W] = dist_q[(i+1)*COORD_W +: COORD_W];
          dist_d[(LW-1)*COORD_W +: COORD_W] = ndist_q;
          ratio_d  = '0;
          state_d  = S_COMMIT;
        end else begin
          ratio_d = ratio_q + RW'(1);
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      layout_q <= LW'(INIT_LAYOUT);
      dist_q   <= {LW{DMIN_C}};
      color_q  <= COLOR_INIT;
      ratio_q  <= '0;
      diffx_q  <= '0;
      diffy_q  <= '0;
      lfsr_q   <= SEED;
      nlay_q   <= 1'b0;
      ncol_q   <= 1'b0;
      ndist_q  <= DMIN_C;
    end else begin
      state_q  <= state_d;
      layout_q <= layout_d;
      dist_q   <= dist_d;
      color_q  <= color_d;
      ratio_q  <= ratio_d;
      diffx_q  <= diffx_d;
      diffy_q  <= diffy_d;
      lfsr_q   <= lfsr_d;
      nlay_q   <= nlay_d;
      ncol_q   <= ncol_d;
      ndist_q  <= ndist_d;
    end
  end

endmodule

// File: tb/tb_platform_scroller.sv
// Self-checking bench for platform_scroller: directed vector table, corner sequences,
// and random advance traffic against a transaction-level reference model.
module tb_platform_scroller;

  localparam int NSQ   = 3;
  localparam int CW    = 8;
  localparam int DMIN  = 13;
  localparam int RNDW  = 3;
  localparam int SFT   = 4;
  localparam int BY    = 100;
  localparam int BXR   = 20;
  localparam int BXL   = 40;
  localparam int STEPS = 1 << SFT;
  localparam int MASK  = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                adv;
  logic [NSQ*CW-1:0]   plat_x, plat_y;
  logic [NSQ-1:0]      plat_color;
  logic                busy, done;

  always #5 clk = ~clk;

  platform_scroller #(
    .NUM_SQ(NSQ), .COORD_W(CW), .DIST_MIN(DMIN), .DIST_RND_W(RNDW), .STEP_SFT(SFT),
    .BASE_Y(BY), .BASE_XR(BXR), .BASE_XL(BXL), .INIT_LAYOUT(1), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .adv(adv),
    .plat_x(plat_x), .plat_y(plat_y), .plat_color(plat_color),
    .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floordiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int px(input int i);
    return plat_x[i*CW +: CW];
  endfunction

  function automatic int py(input int i);
    return plat_y[i*CW +: CW];
  endfunction

  // Reference model: chain kept as plain integer arrays, scroll tracked as a
  // cycle count t (0 idle, 1 generate, 2..STEPS+2 scroll with ratio t-2, STEPS+3 commit).
  int          m_lay  [NSQ-1];
  int          m_dist [NSQ-1];
  int          m_col  [NSQ];
  logic [15:0] m_lfsr;
  int          m_t;
  int          m_nl, m_nc, m_nd, m_dx, m_dy;
  bit          model_on = 1'b0;

  function automatic int mx(input int i);
    int x;
    x = m_lay[0] ? BXL : BXR;
    for (int k = 1; k <= i; k++) x = m_lay[k-1] ? x - m_dist[k-1] : x + m_dist[k-1];
    return x & MASK;
  endfunction

  function automatic int my(input int i);
    int y;
    y = BY;
    for (int k = 1; k <= i; k++) y = y - m_dist[k-1];
    return y & MASK;
  endfunction

  function automatic int m_ratio();
    return (m_t >= 2 && m_t <= STEPS + 2) ? m_t - 2 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NSQ - 1; k++) begin
      m_lay[k]  = (k == 0) ? 1 : 0;
      m_dist[k] = DMIN;
    end
    for (int k = 0; k < NSQ; k++) m_col[k] = (k % 2 == 0) ? 1 : 0;
    m_lfsr = 16'hACE1;
    m_t    = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      if (m_t == 0) begin
        if (adv) m_t = 1;
      end else if (m_t == 1) begin
        m_nl = (m_lfsr[3:0] > 13) ? m_lay[NSQ-2] : 1 - m_lay[NSQ-2];
        m_nc = m_lfsr[4];
        m_nd = DMIN + ((m_lfsr >> 5) % (1 << RNDW));
        m_dx = (m_lay[1] ? BXL : BXR) - mx(1);
        m_dy = BY - my(1);
        m_t  = 2;
      end else if (m_t < STEPS + 2) begin
        m_t++;
      end else if (m_t == STEPS + 2) begin
        for (int k = 0; k < NSQ - 2; k++) begin
          m_lay[k]  = m_lay[k+1];
          m_dist[k] = m_dist[k+1];
        end
        m_lay[NSQ-2]  = m_nl;
        m_dist[NSQ-2] = m_nd;
        for (int k = 0; k < NSQ - 1; k++) m_col[k] = m_col[k+1];
        m_col[NSQ-1] = m_nc;
        m_t++;
      end else begin
        m_t = 0;
      end
      if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
      else           m_lfsr = m_lfsr >> 1;
    end
  end

  always @(negedge clk) begin
    if (model_on && !rst) begin
      int ox, oy, r;
      r  = m_ratio();
      ox = (m_t >= 2 && m_t <= STEPS + 2) ? floordiv(m_dx * r, STEPS) : 0;
      oy = (m_t >= 2 && m_t <= STEPS + 2) ? floordiv(m_dy * r, STEPS) : 0;
      check("model_busy", busy, (m_t != 0));
      check("model_done", done, (m_t == STEPS + 3));
      for (int i = 0; i < NSQ; i++) begin
        check($sformatf("model_x%0d", i), px(i), (mx(i) + ox) & MASK);
        check($sformatf("model_y%0d", i), py(i), (my(i) + oy) & MASK);
        check($sformatf("model_col%0d", i), plat_color[i], m_col[i]);
      end
    end
  end

  typedef struct {
    logic adv;
    logic busy;
    logic done;
    int   x0, y0, x1, y1;
  } vec_t;

  vec_t tbl [21];

  task automatic check_reset_layout(input string tag);
    check({tag, "_x0"}, px(0), 40);
    check({tag, "_x1"}, px(1), 27);
    check({tag, "_x2"}, px(2), 40);
    check({tag, "_y0"}, py(0), 100);
    check({tag, "_y1"}, py(1), 87);
    check({tag, "_y2"}, py(2), 74);
    check({tag, "_color"}, plat_color, 3'b101);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, gap, r;

    for (int i = 0; i < 21; i++) begin
      tbl[i].adv  = (i == 0);
      tbl[i].busy = (i >= 1 && i <= 19);
      tbl[i].done = (i == 19);
      if (i <= 1) begin
        tbl[i].x0 = 40; tbl[i].y0 = 100; tbl[i].x1 = 27; tbl[i].y1 = 87;
      end else if (i <= 18) begin
        r = i - 2;
        tbl[i].x0 = (40 + floordiv(-7 * r, STEPS)) & MASK;
        tbl[i].y0 = (100 + floordiv(13 * r, STEPS)) & MASK;
        tbl[i].x1 = (27 + floordiv(-7 * r, STEPS)) & MASK;
        tbl[i].y1 = (87 + floordiv(13 * r, STEPS)) & MASK;
      end else begin
        tbl[i].x0 = 20; tbl[i].y0 = 100; tbl[i].x1 = -1; tbl[i].y1 = -1;
      end
    end

    rst = 1'b1;
    adv = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_layout("reset");
    rst = 1'b0;
    model_on = 1'b1;

    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("vec%0d_done", i), done, tbl[i].done);
      check($sformatf("vec%0d_x0", i), px(0), tbl[i].x0);
      check($sformatf("vec%0d_y0", i), py(0), tbl[i].y0);
      if (tbl[i].x1 >= 0) begin
        check($sformatf("vec%0d_x1", i), px(1), tbl[i].x1);
        check($sformatf("vec%0d_y1", i), py(1), tbl[i].y1);
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      adv = tbl[i].adv;
    end
    check("first_busy_cycles", busy_cnt, 19);
    check("first_done_pulses", done_cnt, 1);

    // Reset in the middle of a scroll, at ratio 10.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    adv = 1'b1;
    @(negedge clk);
    adv = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_x0_ratio10", px(0), 35);
    #2 rst = 1'b1;
    #1 check_reset_layout("async_rst");
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("after_rst_idle", busy, 1'b0);
    check("after_rst_no_done", done_cnt, 0);

    // Held advance: back-to-back scrolls separated by one idle cycle.
    adv = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_done($sformatf("held%0d", s));
      gap = (py(NSQ-2) - py(NSQ-1)) & MASK;
      check($sformatf("held%0d_gap_in_range", s), (gap >= 13 && gap <= 20), 1'b1);
      @(negedge clk);
      check($sformatf("held%0d_idle_gap", s), busy, 1'b0);
      @(negedge clk);
      check($sformatf("held%0d_retrigger", s), busy, 1'b1);
    end
    adv = 1'b0;
    wait_done("held_drain");
    @(negedge clk);

    // Advance pulsed during the scroll is dropped.
    adv = 1'b1;
    @(negedge clk);
    adv = 1'b0;
    repeat (5) @(negedge clk);
    adv = 1'b1;
    @(negedge clk);
    adv = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("pulse_in_shift_done_count", done_cnt, 1);
    check("pulse_in_shift_idle", busy, 1'b0);

    // Random advance traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      adv = ($urandom_range(0, 9) < 3);
    end
    adv = 1'b0;
    repeat (25) @(negedge clk);

`ifndef PLAT_AUTO_ADVANCE_EN
    busy_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("no_auto_advance", busy_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
